hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//   Parametrised hazard / flush controller for the 3-stage core, successor to
//   the no-stall/no-flush pipeline. Tracks in-flight register writes after
//   decode, drives operand-forwarding selects, load-use stalls and
//   taken-branch flushes with PC redirect, and counts stall/flush cycles.
//   Sits beside STAGE1 (fetch/decode), fed by STAGE2/STAGE3 status.
// PARAMETERS
//   DEPTH    2   in-flight entries after decode (0 = EX, DEPTH-1 = oldest/WB)
//   REG_W    5   register-address width
//   PC_W     8   PC width (matches PC4 bus)
//   LOAD_LAT 1   entry index at which load data becomes forwardable; 1..DEPTH-1
//   CNT_W    32  performance-counter width
//   SEL_W    = $clog2(DEPTH+1), forward-select width (derived)
// PORTS
//   clk           in   1      core clock
//   rst           in   1      reset: asynchronous, active-low
//   dec_valid     in   1      decode holds a valid instruction
//   dec_rs1       in   REG_W  source 1 address
//   dec_rs2       in   REG_W  source 2 address
//   dec_use_rs1   in   1      instruction reads rs1
//   dec_use_rs2   in   1      instruction reads rs2
//   dec_rd        in   REG_W  destination address
//   dec_regwrite  in   1      instruction writes rd
//   dec_is_load   in   1      instruction is a load
//   br_taken      in   1      branch in EX (entry 0) resolved taken
//   br_target     in   PC_W   target of that branch
//   cnt_clr       in   1      synchronous counter clear
//   stall_o       out  1      hold PC and decode register, inject bubble
//   flush_o       out  1      kill instruction in decode
//   fwd_sel1      out  SEL_W  rs1 source: 0 = regfile, k+1 = entry k
//   fwd_sel2      out  SEL_W  rs2 source, same encoding
//   redir_valid   out  1      PC redirect request
//   redir_pc      out  PC_W   redirect target, 0 when redir_valid=0
//   stall_cnt     out  CNT_W  cycles stalled
//   flush_cnt     out  CNT_W  flushes taken
// BEHAVIOUR
//   - Reset (rst=0, async): all entries invalid, counters 0. Consequently all
//     outputs are 0 while in reset and in the first cycle after it.
//   - Entry = {valid, rd, regwrite, is_load}. Every clk: entry[k+1]<=entry[k];
//     entry[DEPTH-1] retires; entry[0]<=issue ? dec fields : bubble(valid=0).
//     issue = dec_valid & ~stall_o & ~flush_o. The downstream pipe never stalls.
//   - Match(src): use & src!=0 & entry.valid & entry.regwrite & entry.rd==src.
//     Youngest (lowest k) match wins; older matches are ignored.
//   - Data ready at entry k iff !is_load or k>=LOAD_LAT. Matched and ready ->
//     fwd_sel=k+1. Matched and not ready -> load-use stall, fwd_sel=0. No match
//     -> 0. Outputs are combinational from state + dec inputs (0-cycle latency).
//   - stall_o = dec_valid & (load-use on rs1 | rs2) & ~flush_o.
//   - flush_o = br_taken & entry[0].valid. redir_valid=flush_o,
//     redir_pc=br_target. br_taken with an invalid entry 0 is ignored.
//   - Flush has priority over stall. When both would apply: stall_o=0, the
//     decode instruction is not issued, and only flush_cnt counts.
//   - stall_cnt +1 per cycle stall_o=1. flush_cnt +1 per cycle flush_o=1.
//     Both saturate at all-ones. cnt_clr beats a same-cycle increment
//     (result is 0).
//   - rd=0 writes are recorded but never match. Reset mid-stream drops all
//     entries, so no stale forward is possible.
// TESTING
//   1 add x5 issued, next cycle sub reads rs1=x5 -> fwd_sel1=1, stall_o=0.
//   2 lw x6, next cycle rs2=x6 -> stall_o=1 one cycle, stall_cnt=1; next cycle
//     fwd_sel2=2, stall_o=0.
//   3 producer rd=x0, consumer rs1=x0 -> fwd_sel1=0, no stall.
//   4 load-use stall pending while br_taken=1, br_target=8'h40 -> flush_o=1,
//     stall_o=0, redir_pc=8'h40, entry[0] becomes bubble, flush_cnt=1,
//     stall_cnt unchanged.
//   5 x7 written by entries 0 and 1 -> fwd_sel1=1. CNT_W=4, 20 stall cycles
//     -> stall_cnt=15. cnt_clr with a stall in the same cycle -> 0.
//   6 rst=0 mid-stream with valid entries -> outputs 0 immediately;
//     consumer of old rd after release -> fwd_sel=0.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Hazard / flush controller for the 3-stage core: tracks in-flight writers after
// decode, picks forwarding sources, raises load-use stalls and branch flushes.
module hazard_flush_ctrl #(
  parameter  int DEPTH    = 2,
  parameter  int REG_W    = 5,
  parameter  int PC_W     = 8,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 32,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_regwrite,
  input  logic             dec_is_load,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             cnt_clr,
  output logic             stall_o,
  output logic             flush_o,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             redir_valid,
  output logic [PC_W-1:0]  redir_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             ent_valid [DEPTH];
  logic [REG_W-1:0] ent_rd    [DEPTH];
  logic             ent_rw    [DEPTH];
  logic             ent_ld    [DEPTH];

  logic [SEL_W-1:0] sel1, sel2;
  logic             load_use1, load_use2;
  logic             issue;

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    sel1      = '0;
    sel2      = '0;
    load_use1 = 1'b0;
    load_use2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (dec_use_rs1 && (dec_rs1 != '0) && ent_valid[k] && ent_rw[k] &&
          (ent_rd[k] == dec_rs1)) begin
        if (!ent_ld[k] || (k >= LOAD_LAT)) begin
          sel1      = SEL_W'(k + 1);
          load_use1 = 1'b0;
        end else begin
          sel1      = '0;
          load_use1 = 1'b1;
        end
      end
      if (dec_use_rs2 && (dec_rs2 != '0) && ent_valid[k] && ent_rw[k] &&
          (ent_rd[k] == dec_rs2)) begin
        if (!ent_ld[k] || (k >= LOAD_LAT)) begin
          sel2      = SEL_W'(k + 1);
          load_use2 = 1'b0;
        end else begin
          sel2      = '0;
          load_use2 = 1'b1;
        end
      end
    end
  end

  assign flush_o     = br_taken & ent_valid[0];
  assign stall_o     = dec_valid & (load_use1 | load_use2) & ~flush_o;
  assign issue       = dec_valid & ~stall_o & ~flush_o;
  assign redir_valid = flush_o;
  assign redir_pc    = flush_o ? br_target : '0;
  assign fwd_sel1    = sel1;
  assign fwd_sel2    = sel2;

  // Downstream never stalls, so the tracker shifts every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_valid[k] <= 1'b0;
        ent_rd[k]    <= '0;
        ent_rw[k]    <= 1'b0;
        ent_ld[k]    <= 1'b0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_rd[k]    <= ent_rd[k-1];
        ent_rw[k]    <= ent_rw[k-1];
        ent_ld[k]    <= ent_ld[k-1];
      end
      ent_valid[0] <= issue;
      ent_rd[0]    <= dec_rd;
      ent_rw[0]    <= dec_regwrite;
      ent_ld[0]    <= dec_is_load;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: each cycle's expected outputs are
// queued when stimulus is applied and compared mid-cycle.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_use_rs1, dec_use_rs2, dec_regwrite, dec_is_load;
  logic       br_taken;
  logic [7:0] br_target;
  logic       cnt_clr;
  logic       stall_o, flush_o, redir_valid;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [7:0] redir_pc;
  logic [3:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic       rv;
    logic [7:0] rpc;
    logic [3:0] scnt;
    logic [3:0] fcnt;
  } obs_t;

  typedef struct packed {
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic [7:0] tgt;
    logic       clr;
    logic       es;
    logic       ef;
    logic [1:0] e1;
    logic [1:0] e2;
  } stim_t;

  obs_t       sb[$];
  logic [3:0] m_scnt = 4'd0;
  logic [3:0] m_fcnt = 4'd0;

  hazard_flush_ctrl #(.DEPTH(2), .REG_W(5), .PC_W(8), .LOAD_LAT(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_is_load(dec_is_load),
    .br_taken(br_taken), .br_target(br_target), .cnt_clr(cnt_clr),
    .stall_o(stall_o), .flush_o(flush_o),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic ld, input logic br,
                               input logic [7:0] tgt, input logic clr, input logic es,
                               input logic ef, input logic [1:0] e1, input logic [1:0] e2);
    stim_t s;
    s.dv = dv; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.rw = rw; s.ld = ld; s.br = br; s.tgt = tgt; s.clr = clr;
    s.es = es; s.ef = ef; s.e1 = e1; s.e2 = e2;
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.stall = stall_o; o.flush = flush_o; o.sel1 = fwd_sel1; o.sel2 = fwd_sel2;
    o.rv = redir_valid; o.rpc = redir_pc; o.scnt = stall_cnt; o.fcnt = flush_cnt;
    return o;
  endfunction

  // Drives one cycle of decode/branch inputs and queues what the DUT should show.
  task automatic apply(input stim_t s);
    obs_t e;
    dec_valid = s.dv; dec_rs1 = s.rs1; dec_rs2 = s.rs2;
    dec_use_rs1 = s.u1; dec_use_rs2 = s.u2; dec_rd = s.rd;
    dec_regwrite = s.rw; dec_is_load = s.ld; br_taken = s.br;
    br_target = s.tgt; cnt_clr = s.clr;
    e.stall = s.es; e.flush = s.ef; e.sel1 = s.e1; e.sel2 = s.e2;
    e.rv = s.ef; e.rpc = s.ef ? s.tgt : 8'h00; e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    if (s.clr) begin
      m_scnt = 4'd0;
      m_fcnt = 4'd0;
    end else begin
      if (s.es && m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
      if (s.ef && m_fcnt != 4'hF) m_fcnt = m_fcnt + 4'd1;
    end
  endtask

  task automatic test_reset();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 1, 2, 1, 1, 1, 1, 0, 1, 8'h21, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 1, 2, 1, 1, 1, 1, 1, 1, 8'h22, 0, 0, 0, 2'd0, 2'd0));
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL reset_hold step %0d: got %h expected %h", i, g, e);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    apply(st(1, 1, 2, 1, 1, 0, 0, 0, 1, 8'h23, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    e = sb.pop_front(); g = observe(); total++;
    if (g !== e) begin
      bad++;
      $display("[TB] FAIL reset_first_cycle: got %h expected %h", g, e);
    end
  endtask

  task automatic test_forward();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(idle());
    seq.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 5, 0, 1, 0, 8, 1, 0, 0, 8'h00, 0, 0, 0, 2'd1, 2'd0));
    seq.push_back(st(1, 5, 8, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd2, 2'd1));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL forward step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 0, 0, 0, 0, 6, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 6, 0, 1, 9, 1, 0, 0, 8'h00, 0, 1, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 6, 0, 1, 9, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd2));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL load_use step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_x0();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 0, 1, 1, 3, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL x0_no_match step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_flush();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 0, 0, 0, 0, 6, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 6, 0, 1, 9, 1, 0, 1, 8'h40, 0, 0, 1, 2'd0, 2'd0));
    seq.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h55, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL flush step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_midstream();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 0, 0, 0, 0, 11, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 11, 0, 1, 0, 12, 1, 0, 0, 8'h00, 0, 0, 0, 2'd1, 2'd0));
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL midreset_setup step %0d: got %h expected %h", i, g, e);
      end
    end
    @(posedge clk); #1;
    m_scnt = 4'd0;
    m_fcnt = 4'd0;
    apply(st(1, 11, 12, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    #1 rst = 1'b0;
    @(negedge clk);
    e = sb.pop_front(); g = observe(); total++;
    if (g !== e) begin
      bad++;
      $display("[TB] FAIL midreset_assert: got %h expected %h", g, e);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    apply(st(1, 11, 12, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    e = sb.pop_front(); g = observe(); total++;
    if (g !== e) begin
      bad++;
      $display("[TB] FAIL midreset_release: got %h expected %h", g, e);
    end
  endtask

  task automatic test_youngest();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(idle());
    seq.push_back(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    seq.push_back(st(1, 7, 7, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd1, 2'd1));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL youngest step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // A self-dependent load re-presented every cycle stalls every other cycle.
  task automatic test_back_to_back();
    stim_t seq[$];
    obs_t  e, g;
    seq.push_back(st(1, 6, 0, 1, 0, 6, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0, 2'd0));
    for (int n = 1; n <= 40; n++) begin
      if (n % 2 == 1) seq.push_back(st(1, 6, 0, 1, 0, 6, 1, 1, 0, 8'h00, 0, 1, 0, 2'd0, 2'd0));
      else            seq.push_back(st(1, 6, 0, 1, 0, 6, 1, 1, 0, 8'h00, 0, 0, 0, 2'd2, 2'd0));
    end
    seq.push_back(st(1, 6, 0, 1, 0, 6, 1, 1, 0, 8'h00, 1, 1, 0, 2'd0, 2'd0));
    seq.push_back(idle());
    seq.push_back(idle());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front(); g = observe(); total++;
      if (g !== e) begin
        bad++;
        $display("[TB] FAIL back_to_back step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    dec_rd = 0; dec_regwrite = 0; dec_is_load = 0; br_taken = 0; br_target = 0;
    cnt_clr = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_midstream();
    test_youngest();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
